// File: rtl/irq_pending_if.sv
// rtl/irq_pending_if.sv - request/ack/encoder-side signal bundle for irq_pending
interface irq_pending_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic [WIDTH-1:0] irq_in;
    logic [WIDTH-1:0] edge_mode;
    logic [WIDTH-1:0] mask;
    logic             ack;
    logic [IDX_W-1:0] ack_idx;
    logic [WIDTH-1:0] d;
    logic             ena;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] overrun;

    modport master (
        output irq_in, edge_mode, mask, ack, ack_idx,
        input  d, ena, pending, overrun
    );

    modport slave (
        input  irq_in, edge_mode, mask, ack, ack_idx,
        output d, ena, pending, overrun
    );
endinterface

// File: rtl/irq_pending.sv
// rtl/irq_pending.sv - synchronised pending-request capture feeding an 8-to-3 priority encoder
module irq_pending #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_pending_if.slave bus
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_overrun;
    logic [WIDTH-1:0] r_d;
    logic             r_ena;

    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_pend_next;
    logic [WIDTH-1:0] w_ovr_next;
    logic [WIDTH-1:0] w_d_next;

    // Indices at or above WIDTH never match, so out-of-range acks are ignored.
    always_comb begin
        w_set       = '0;
        w_clr       = '0;
        w_pend_next = '0;
        w_ovr_next  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_set[i]       = bus.edge_mode[i] ? (r_s2[i] & ~r_prev[i]) : r_s2[i];
            w_clr[i]       = bus.ack && (int'(bus.ack_idx) == i);
            w_pend_next[i] = w_set[i] | (r_pending[i] & ~w_clr[i]);
            if (bus.edge_mode[i] && w_set[i] && r_pending[i] && !w_clr[i]) begin
                w_ovr_next[i] = 1'b1;
            end else if (w_clr[i]) begin
                w_ovr_next[i] = 1'b0;
            end else begin
                w_ovr_next[i] = r_overrun[i];
            end
        end
        w_d_next = w_pend_next & bus.mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_prev    <= '0;
            r_pending <= '0;
            r_overrun <= '0;
            r_d       <= '0;
            r_ena     <= 1'b0;
        end else begin
            r_s1      <= bus.irq_in;
            r_s2      <= r_s1;
            r_prev    <= r_s2;
            r_pending <= w_pend_next;
            r_overrun <= w_ovr_next;
            r_d       <= w_d_next;
            r_ena     <= |w_d_next;
        end
    end

    assign bus.d       = r_d;
    assign bus.ena     = r_ena;
    assign bus.pending = r_pending;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_irq_pending.sv
// tb/tb_irq_pending.sv - directed self-checking bench for irq_pending
module tb_irq_pending;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    irq_pending_if #(.WIDTH(8), .IDX_W(3)) bus ();

    irq_pending #(.WIDTH(8), .IDX_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference 8-to-3 priority encoder: highest set bit wins.
    function automatic logic [2:0] enc_n(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic ack_line(input logic [2:0] idx);
        bus.ack     = 1'b1;
        bus.ack_idx = idx;
        tick();
        bus.ack     = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        bus.irq_in = v;
        tick();
        bus.irq_in = 8'h00;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.irq_in    = 8'hFF;
        bus.edge_mode = 8'hFF;
        bus.mask      = 8'hFF;
        bus.ack       = 1'b0;
        bus.ack_idx   = 3'd0;

        tick();
        check("rst1_d", bus.d, 8'h00);
        check("rst1_ena", {7'd0, bus.ena}, 8'h00);
        check("rst1_pending", bus.pending, 8'h00);
        check("rst1_overrun", bus.overrun, 8'h00);
        tick();
        check("rst2_d", bus.d, 8'h00);
        check("rst2_pending", bus.pending, 8'h00);
        rst_n = 1'b1;
        tick();
        check("rel_e1_pending", bus.pending, 8'h00);
        tick();
        check("rel_e2_pending", bus.pending, 8'h00);
        tick();
        check("rel_e3_pending", bus.pending, 8'hFF);
        check("rel_e3_d", bus.d, 8'hFF);
        bus.irq_in = 8'h00;
        for (int i = 0; i < 8; i++) ack_line(3'(i));
        check("clrall_pending", bus.pending, 8'h00);
        check("clrall_ena", {7'd0, bus.ena}, 8'h00);
        check("clrall_overrun", bus.overrun, 8'h00);

        pulse(8'h20);
        tick();
        check("edge_lat2_d", bus.d, 8'h00);
        tick();
        check("edge_d", bus.d, 8'h20);
        check("edge_ena", {7'd0, bus.ena}, 8'h01);
        check("edge_n", {5'd0, enc_n(bus.d)}, 8'd5);
        ack_line(3'd5);
        check("edge_ack_d", bus.d, 8'h00);
        check("edge_ack_ena", {7'd0, bus.ena}, 8'h00);

        pulse(8'h89);
        tick();
        tick();
        check("prio_d", bus.d, 8'h89);
        check("prio_n7", {5'd0, enc_n(bus.d)}, 8'd7);
        ack_line(3'd7);
        check("prio_n3", {5'd0, enc_n(bus.d)}, 8'd3);
        ack_line(3'd3);
        check("prio_n0", {5'd0, enc_n(bus.d)}, 8'd0);
        check("prio_d0", bus.d, 8'h01);
        ack_line(3'd0);
        check("prio_ena0", {7'd0, bus.ena}, 8'h00);

        bus.mask = 8'h01;
        pulse(8'h81);
        tick();
        tick();
        check("mask_pending", bus.pending, 8'h81);
        check("mask_d", bus.d, 8'h01);
        bus.mask = 8'hFF;
        tick();
        check("unmask_d", bus.d, 8'h81);
        check("unmask_pending", bus.pending, 8'h81);
        ack_line(3'd0);
        ack_line(3'd7);
        check("mask_clr_pending", bus.pending, 8'h00);

        ack_line(3'd6);
        check("ack_idle_pending", bus.pending, 8'h00);

        bus.edge_mode = 8'hFB;
        bus.irq_in    = 8'h04;
        tick();
        tick();
        tick();
        check("lvl_set", bus.pending, 8'h04);
        bus.ack     = 1'b1;
        bus.ack_idx = 3'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lvl_setwins", bus.pending, 8'h04);
        end
        bus.irq_in = 8'h00;
        tick();
        tick();
        check("lvl_drop2", bus.pending, 8'h04);
        tick();
        check("lvl_drop3", bus.pending, 8'h00);
        bus.ack = 1'b0;
        check("lvl_no_ovr", bus.overrun, 8'h00);
        bus.edge_mode = 8'hFF;

        pulse(8'h10);
        tick();
        tick();
        check("ovr_first", bus.pending, 8'h10);
        check("ovr_none_yet", bus.overrun, 8'h00);
        pulse(8'h10);
        tick();
        tick();
        check("ovr_flag", bus.overrun, 8'h10);
        check("ovr_pending", bus.pending, 8'h10);
        ack_line(3'd4);
        check("ovr_clr_flag", bus.overrun, 8'h00);
        check("ovr_clr_pending", bus.pending, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
